// File: rtl/risc5_intctrl.sv
// Prioritised, maskable interrupt controller for the RISC5 CPU.
// Edge-captures up to 16 sources, raises one request and latches the winner on intack.
module risc5_intctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               intack,
  input  logic               rti,
  output logic               irq_out,
  input  logic [1:0]         adr,
  input  logic               rd,
  input  logic               wr,
  input  logic [31:0]        din,
  output logic [31:0]        dout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] prev_q;
  logic               cur_valid_q, cur_valid_d;
  logic [3:0]         cur_id_q, cur_id_d;
  logic               irq_out_q;

  logic [NUM_IRQ-1:0] set_s;
  logic [NUM_IRQ-1:0] elig_s;
  logic [NUM_IRQ-1:0] w1c_s;
  logic [NUM_IRQ-1:0] ack_clr_s;
  logic [3:0]         winner_s;
  logic               unused_din_s;

  // Lowest-index set bit wins.
  function automatic logic [3:0] first_set(input logic [NUM_IRQ-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = 4'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign unused_din_s = ^din;

  always_comb begin
    set_s     = irq_in & ~prev_q;
    elig_s    = pend_q & mask_q;
    winner_s  = first_set(elig_s);
    w1c_s     = (wr && (adr == 2'd0)) ? din[NUM_IRQ-1:0] : '0;
    mask_d    = (wr && (adr == 2'd1)) ? din[NUM_IRQ-1:0] : mask_q;
    state_d     = state_q;
    cur_valid_d = cur_valid_q;
    cur_id_d    = cur_id_q;
    ack_clr_s   = '0;
    case (state_q)
      IDLE: begin
        if (intack) begin
          state_d     = SERVICE;
          cur_valid_d = 1'b0;
          cur_id_d    = 4'd0;
        end else if (elig_s != '0) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (intack) begin
          state_d = SERVICE;
          if (elig_s != '0) begin
            cur_valid_d = 1'b1;
            cur_id_d    = winner_s;
            for (int i = 0; i < NUM_IRQ; i++) begin
              ack_clr_s[i] = (winner_s == 4'(i));
            end
          end else begin
            cur_valid_d = 1'b0;
            cur_id_d    = 4'd0;
          end
        end else if (elig_s == '0) begin
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      SERVICE: begin
        if (rti) begin
          state_d     = IDLE;
          cur_valid_d = 1'b0;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A new edge beats a same-cycle clear so no event is lost.
    pend_d = (pend_q & ~(w1c_s | ack_clr_s)) | set_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      mask_q      <= '0;
      prev_q      <= '0;
      cur_valid_q <= 1'b0;
      cur_id_q    <= 4'd0;
      irq_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      prev_q      <= irq_in;
      cur_valid_q <= cur_valid_d;
      cur_id_q    <= cur_id_d;
      irq_out_q   <= (state_d == REQ);
    end
  end

  assign irq_out = irq_out_q;

  always_comb begin
    if (rd) begin
      case (adr)
        2'd0:    dout = 32'(pend_q);
        2'd1:    dout = 32'(mask_q);
        2'd2:    dout = {cur_valid_q, 27'd0, cur_id_q};
        2'd3:    dout = {23'd0, irq_out_q, 6'd0, state_q};
        default: dout = 32'd0;
      endcase
    end else begin
      dout = 32'd0;
    end
  end

endmodule
